// File: rtl/pc_seq_pkg.sv
// Shared types and address helpers for the PC/nPC sequencer.
// Helpers work on PcMaxW-bit values, so PC_SIZE must not exceed PcMaxW.
package pc_seq_pkg;

  localparam int unsigned PcMaxW = 64;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt,
    StFault
  } pc_seq_state_e;

  // Sequential increment; callers truncate to their own width for modulo wrap.
  function automatic logic [PcMaxW-1:0] pc_incr(input logic [PcMaxW-1:0] pc,
                                                input int unsigned         insn_bytes);
    return pc + PcMaxW'(insn_bytes);
  endfunction

  // Mask that clears the instruction-offset bits of an address.
  function automatic logic [PcMaxW-1:0] align_mask(input int unsigned insn_bytes);
    return ~(PcMaxW'(insn_bytes) - PcMaxW'(1));
  endfunction

endpackage

// File: rtl/pc_seq_fsm.sv
// Sequencer control FSM: BOOT -> RUN <-> HALT, with FAULT left only by a trap.
module pc_seq_fsm
  import pc_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          trap_valid,
  input  logic          branch_fault,
  output pc_seq_state_e state,
  output logic          fetch_valid
);

  pc_seq_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!trap_valid) begin
          if (branch_fault) begin
            state_d = StFault;
          end else if (halt) begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (!trap_valid) begin
          if (branch_fault) begin
            state_d = StFault;
          end else if (!halt) begin
            state_d = StRun;
          end
        end
      end
      StFault: begin
        if (trap_valid) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  assign state       = state_q;
  assign fetch_valid = (state_q == StRun);

endmodule

// File: rtl/pc_sequencer.sv
// SPARC-style PC/nPC sequencer feeding instruction fetch over a valid/ready handshake.
// Optional misaligned-branch trapping is enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_SIZE    = 64,
  parameter int unsigned INSN_BYTES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_SIZE-1:0] entry,
  input  logic               if_ready,
  input  logic               halt,
  input  logic               br_valid,
  input  logic               br_taken,
  input  logic               br_annul,
  input  logic [PC_SIZE-1:0] br_target,
  input  logic               trap_valid,
  input  logic [PC_SIZE-1:0] trap_vector,
  output logic               fetch_valid,
  output logic [PC_SIZE-1:0] fetch_pc,
  output logic [PC_SIZE-1:0] fetch_npc,
  output logic               fetch_annul,
  output logic               align_fault
);

  localparam logic [PC_SIZE-1:0] AlignMask = PC_SIZE'(align_mask(INSN_BYTES));

  function automatic logic [PC_SIZE-1:0] next_addr(input logic [PC_SIZE-1:0] a);
    return PC_SIZE'(pc_incr(PcMaxW'(a), INSN_BYTES));
  endfunction

  pc_seq_state_e      state;
  logic [PC_SIZE-1:0] pc_q, pc_d, npc_q, npc_d, br_tgt, redirect, trap_tgt;
  logic               annul_q, annul_d;
  logic               advance, br_accept, branch_fault;

  assign advance   = fetch_valid & if_ready;
  assign br_accept = br_valid & ~trap_valid & ((state == StRun) | (state == StHalt));
  assign trap_tgt  = trap_vector & AlignMask;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic align_fault_q;

  assign br_tgt       = br_target;
  assign branch_fault = br_accept & br_taken & (|(br_target & ~AlignMask));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= branch_fault;
    end
  end

  assign align_fault = align_fault_q;
`else
  assign br_tgt       = br_target & AlignMask;
  assign branch_fault = 1'b0;
  assign align_fault  = 1'b0;
`endif

  pc_seq_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .halt         (halt),
    .trap_valid   (trap_valid),
    .branch_fault (branch_fault),
    .state        (state),
    .fetch_valid  (fetch_valid)
  );

  // Address that becomes PC when a branch retires together with its delay slot.
  assign redirect = br_taken ? br_tgt : npc_q;

  always_comb begin
    pc_d    = pc_q;
    npc_d   = npc_q;
    annul_d = annul_q;
    if (state == StBoot) begin
      pc_d    = entry;
      npc_d   = next_addr(entry);
      annul_d = 1'b0;
    end else if (trap_valid) begin
      pc_d    = trap_tgt;
      npc_d   = next_addr(trap_tgt);
      annul_d = 1'b0;
    end else if (br_accept) begin
      if (branch_fault) begin
        // Misaligned target: hold everything, FSM parks in FAULT.
      end else if (advance) begin
        pc_d    = redirect;
        npc_d   = next_addr(redirect);
        annul_d = 1'b0;
      end else begin
        if (br_taken) begin
          npc_d = br_tgt;
        end
        annul_d = br_annul;
      end
    end else if (advance) begin
      pc_d    = npc_q;
      npc_d   = next_addr(npc_q);
      annul_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      npc_q   <= '0;
      annul_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      annul_q <= annul_d;
    end
  end

  assign fetch_pc    = pc_q;
  assign fetch_npc   = npc_q;
  assign fetch_annul = fetch_valid & (annul_q | (br_valid & br_annul));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_SIZE=64, INSN_BYTES=4).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        if_ready, halt;
  logic        br_valid, br_taken, br_annul;
  logic [63:0] br_target;
  logic        trap_valid;
  logic [63:0] trap_vector;
  logic        fetch_valid;
  logic [63:0] fetch_pc, fetch_npc;
  logic        fetch_annul, align_fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_SIZE    (64),
    .INSN_BYTES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry       (entry),
    .if_ready    (if_ready),
    .halt        (halt),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_annul    (br_annul),
    .br_target   (br_target),
    .trap_valid  (trap_valid),
    .trap_vector (trap_vector),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_npc   (fetch_npc),
    .fetch_annul (fetch_annul),
    .align_fault (align_fault)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    br_annul   = 1'b0;
    br_target  = '0;
    trap_valid = 1'b0;
  endtask

  // Leaves the DUT in RUN with fetch_pc == boot address.
  task automatic do_reset(input logic [63:0] boot);
    entry = boot;
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
    #1;
    check("boot_valid", {63'd0, fetch_valid}, 64'd0);
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    entry       = 64'h1000;
    if_ready    = 1'b0;
    halt        = 1'b0;
    trap_vector = '0;
    clear_br();
    tick();
    tick();
    check("rst_valid", {63'd0, fetch_valid}, 64'd0);
    check("rst_pc", fetch_pc, 64'd0);
    check("rst_npc", fetch_npc, 64'd0);
    check("rst_annul", {63'd0, fetch_annul}, 64'd0);
    check("rst_fault", {63'd0, align_fault}, 64'd0);

    // Sequential fetch from the boot address.
    if_ready = 1'b1;
    do_reset(64'h1000);
    check("seq_valid", {63'd0, fetch_valid}, 64'd1);
    check("seq_pc0", fetch_pc, 64'h1000);
    check("seq_npc0", fetch_npc, 64'h1004);
    tick();
    check("seq_pc1", fetch_pc, 64'h1004);
    tick();
    check("seq_pc2", fetch_pc, 64'h1008);
    check("seq_npc2", fetch_npc, 64'h100c);

    // Taken branch retiring with its delay slot.
    do_reset(64'h1000);
    tick();
    br_valid = 1'b1; br_taken = 1'b1; br_target = 64'h2000;
    #1;
    check("br_slot_annul", {63'd0, fetch_annul}, 64'd0);
    tick();
    clear_br();
    check("br_pc", fetch_pc, 64'h2000);
    check("br_npc", fetch_npc, 64'h2004);

    // Not-taken annulling branch while IF stalls.
    do_reset(64'h1000);
    tick();
    if_ready = 1'b0;
    br_valid = 1'b1; br_taken = 1'b0; br_annul = 1'b1;
    #1;
    check("ann_comb", {63'd0, fetch_annul}, 64'd1);
    tick();
    clear_br();
    check("ann_hold1", {63'd0, fetch_annul}, 64'd1);
    check("ann_pc1", fetch_pc, 64'h1004);
    tick();
    check("ann_hold2", {63'd0, fetch_annul}, 64'd1);
    if_ready = 1'b1;
    #1;
    check("ann_accept", {63'd0, fetch_annul}, 64'd1);
    tick();
    check("ann_next_pc", fetch_pc, 64'h1008);
    check("ann_next_npc", fetch_npc, 64'h100c);
    check("ann_cleared", {63'd0, fetch_annul}, 64'd0);

    // Trap wins over a simultaneous taken branch; low bits forced to zero.
    trap_valid = 1'b1; trap_vector = 64'h8003;
    br_valid = 1'b1; br_taken = 1'b1; br_target = 64'h2000;
    tick();
    clear_br();
    check("trap_pc", fetch_pc, 64'h8000);
    check("trap_npc", fetch_npc, 64'h8004);

    // Misaligned taken branch target.
    do_reset(64'h1000);
    br_valid = 1'b1; br_taken = 1'b1; br_target = 64'h2002;
    tick();
    clear_br();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    check("mis_fault", {63'd0, align_fault}, 64'd1);
    check("mis_valid", {63'd0, fetch_valid}, 64'd0);
    check("mis_pc", fetch_pc, 64'h1000);
    tick();
    check("mis_pulse", {63'd0, align_fault}, 64'd0);
    check("mis_parked", {63'd0, fetch_valid}, 64'd0);
    trap_valid = 1'b1; trap_vector = 64'h3000;
    tick();
    clear_br();
    check("mis_trap_valid", {63'd0, fetch_valid}, 64'd1);
    check("mis_trap_pc", fetch_pc, 64'h3000);
`else
    check("mis_fault", {63'd0, align_fault}, 64'd0);
    check("mis_pc", fetch_pc, 64'h2000);
    check("mis_npc", fetch_npc, 64'h2004);
`endif

    // Wrap at the top of the address space, then halt mid-stream.
    if_ready = 1'b0;
    trap_valid = 1'b1; trap_vector = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    clear_br();
    check("wrap_pc0", fetch_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    if_ready = 1'b1;
    tick();
    check("wrap_pc1", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_npc1", fetch_npc, 64'd0);
    tick();
    check("wrap_pc2", fetch_pc, 64'd0);
    check("wrap_npc2", fetch_npc, 64'd4);
    halt = 1'b1;
    tick();
    check("halt_valid", {63'd0, fetch_valid}, 64'd0);
    check("halt_pc", fetch_pc, 64'd4);
    tick();
    check("halt_hold", fetch_pc, 64'd4);
    halt = 1'b0;
    tick();
    check("resume_valid", {63'd0, fetch_valid}, 64'd1);
    check("resume_pc", fetch_pc, 64'd4);

    // Asynchronous reset mid-operation.
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {63'd0, fetch_valid}, 64'd0);
    check("async_pc", fetch_pc, 64'd0);
    check("async_npc", fetch_npc, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
